// File: rtl/sudoku_cell_scheduler.sv
// Cell scheduler for a single-pass 9x9 grid fill.
// Walks the grid in row-major order, skips given cells, offers digits 1..GRID_N
// to the constraint checker over a req/ack handshake, and writes the first
// accepted digit back to grid memory. Reports done, or fail with a reason code.
module sudoku_cell_scheduler #(
    parameter int GRID_N      = 9,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [1:0] fail_code,
    output logic [3:0] rd_row,
    output logic [3:0] rd_col,
    input  logic       rd_fixed,
    output logic       check_req,
    output logic [3:0] check_row,
    output logic [3:0] check_col,
    output logic [3:0] check_digit,
    input  logic       check_ack,
    input  logic       check_ok,
    output logic       wr_en,
    output logic [3:0] wr_row,
    output logic [3:0] wr_col,
    output logic [3:0] wr_digit
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_FWAIT,
        S_REQ,
        S_WRITE,
        S_NEXT,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [3:0] LAST_IDX   = 4'(GRID_N - 1);
    localparam logic [3:0] MAX_DIGIT  = 4'(GRID_N);
    // Last cycle index of an unanswered request before giving up.
    localparam logic [7:0] TIMER_LAST = 8'(ACK_TIMEOUT - 1);

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_NO_CAND = 2'd1;
    localparam logic [1:0] FC_TIMEOUT = 2'd2;

    state_t     state_q, state_d;
    logic [3:0] row_q, row_d;
    logic [3:0] col_q, col_d;
    logic [3:0] digit_q, digit_d;
    logic [7:0] timer_q, timer_d;
    // One-cycle request gap after a rejected digit, still inside REQ.
    logic       gap_q, gap_d;
    logic [1:0] fail_code_q, fail_code_d;

    // State and counter registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            row_q       <= 4'd0;
            col_q       <= 4'd0;
            digit_q     <= 4'd1;
            timer_q     <= 8'd0;
            gap_q       <= 1'b0;
            fail_code_q <= FC_NONE;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            digit_q     <= digit_d;
            timer_q     <= timer_d;
            gap_q       <= gap_d;
            fail_code_q <= fail_code_d;
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        digit_d     = digit_q;
        timer_d     = timer_q;
        gap_d       = gap_q;
        fail_code_d = fail_code_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    row_d       = 4'd0;
                    col_d       = 4'd0;
                    digit_d     = 4'd1;
                    timer_d     = 8'd0;
                    gap_d       = 1'b0;
                    fail_code_d = FC_NONE;
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_FWAIT;
            end
            S_FWAIT: begin
                if (rd_fixed) begin
                    state_d = S_NEXT;
                end else begin
                    digit_d = 4'd1;
                    timer_d = 8'd0;
                    gap_d   = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (gap_q) begin
                    // Request is low this cycle; re-raise it with the new digit.
                    gap_d = 1'b0;
                end else if (check_ack) begin
                    // An ack on the final timeout cycle still counts.
                    if (check_ok) begin
                        state_d = S_WRITE;
                    end else if (digit_q < MAX_DIGIT) begin
                        digit_d = digit_q + 4'd1;
                        timer_d = 8'd0;
                        gap_d   = 1'b1;
                    end else begin
                        fail_code_d = FC_NO_CAND;
                        state_d     = S_FAIL;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    fail_code_d = FC_TIMEOUT;
                    state_d     = S_FAIL;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_WRITE: begin
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (col_q < LAST_IDX) begin
                    col_d   = col_q + 4'd1;
                    state_d = S_FETCH;
                end else begin
                    col_d = 4'd0;
                    if (row_q == LAST_IDX) begin
                        row_d   = 4'd0;
                        state_d = S_DONE;
                    end else begin
                        row_d   = row_q + 4'd1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_FAIL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state; data fields are zero when idle.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        fail        = 1'b0;
        check_req   = 1'b0;
        check_row   = 4'd0;
        check_col   = 4'd0;
        check_digit = 4'd0;
        wr_en       = 1'b0;
        wr_row      = 4'd0;
        wr_col      = 4'd0;
        wr_digit    = 4'd0;
        fail_code   = fail_code_q;
        rd_row      = row_q;
        rd_col      = col_q;

        case (state_q)
            S_FETCH, S_FWAIT, S_NEXT: begin
                busy = 1'b1;
            end
            S_REQ: begin
                busy = 1'b1;
                if (!gap_q) begin
                    check_req   = 1'b1;
                    check_row   = row_q;
                    check_col   = col_q;
                    check_digit = digit_q;
                end
            end
            S_WRITE: begin
                busy     = 1'b1;
                wr_en    = 1'b1;
                wr_row   = row_q;
                wr_col   = col_q;
                wr_digit = digit_q;
            end
            S_DONE: begin
                done = 1'b1;
            end
            S_FAIL: begin
                fail = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_sudoku_cell_scheduler.sv
// Bench for sudoku_cell_scheduler: a grid/checker environment plus a
// cycle-by-cycle expected-output model built from the scan rules.
module tb_sudoku_cell_scheduler;

    localparam int GN = 9;
    localparam int TO = 15;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       fail;
        logic [1:0] fc;
        logic [3:0] rr;
        logic [3:0] rc;
        logic       req;
        logic [3:0] cr;
        logic [3:0] cc;
        logic [3:0] cd;
        logic       wr;
        logic [3:0] wrr;
        logic [3:0] wrc;
        logic [3:0] wrd;
    } obs_t;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] act;
        logic [31:0] exp;
    } lit_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       busy, done, fail;
    logic [1:0] fail_code;
    logic [3:0] rd_row, rd_col;
    logic       rd_fixed = 1'b0;
    logic       check_req;
    logic [3:0] check_row, check_col, check_digit;
    logic       check_ack = 1'b0;
    logic       check_ok = 1'b0;
    logic       wr_en;
    logic [3:0] wr_row, wr_col, wr_digit;

    int fixed_tab [GN][GN];
    int acc_tab   [GN][GN];
    int lat_tab   [GN][GN];

    obs_t exp_q [$];
    lit_t lit_q [$];

    int vectors     = 0;
    int miscompares = 0;
    int dut_wr_cnt   = 0;
    int dut_done_cnt = 0;
    int dut_fail_cnt = 0;

    logic [1:0] m_fc = 2'd0;
    logic [3:0] m_rr = 4'd0;
    logic [3:0] m_rc = 4'd0;

    int snap_wr, snap_done, snap_fail;
    int chk_wait = 0;

    obs_t act_obs, exp_obs;
    lit_t lit_item;

    always #5 clock = ~clock;

    sudoku_cell_scheduler #(.GRID_N(GN), .ACK_TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .start(start),
        .busy(busy), .done(done), .fail(fail), .fail_code(fail_code),
        .rd_row(rd_row), .rd_col(rd_col), .rd_fixed(rd_fixed),
        .check_req(check_req), .check_row(check_row), .check_col(check_col),
        .check_digit(check_digit), .check_ack(check_ack), .check_ok(check_ok),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_digit(wr_digit)
    );

    // Grid memory: given-flag returned one cycle after the address.
    always @(posedge clock) begin
        if (rd_row < 4'(GN) && rd_col < 4'(GN))
            rd_fixed <= (fixed_tab[rd_row][rd_col] != 0);
        else
            rd_fixed <= 1'b0;
    end

    // Checker: acks a held request after the cell's latency; 0 = never.
    always @(posedge clock) begin
        if (reset || check_ack) begin
            check_ack <= 1'b0;
            check_ok  <= 1'b0;
            chk_wait  <= 0;
        end else if (check_req && check_row < 4'(GN) && check_col < 4'(GN)) begin
            if (lat_tab[check_row][check_col] != 0 &&
                chk_wait + 1 >= lat_tab[check_row][check_col]) begin
                check_ack <= 1'b1;
                check_ok  <= (int'(check_digit) == acc_tab[check_row][check_col]);
                chk_wait  <= 0;
            end else begin
                chk_wait <= chk_wait + 1;
            end
        end else begin
            chk_wait <= 0;
        end
    end

    function automatic string lit_name(input logic [7:0] id);
        case (id)
            8'd1:  return "fixed_busy_cycles";
            8'd2:  return "fixed_done_offset";
            8'd3:  return "fixed_wr_count";
            8'd4:  return "fixed_done_count";
            8'd5:  return "retry_req_cycles";
            8'd6:  return "retry_wr_count";
            8'd7:  return "retry_done_count";
            8'd8:  return "nocand_fail_count";
            8'd9:  return "nocand_wr_count";
            8'd10: return "timeout_req_cycles";
            8'd11: return "timeout_fail_count";
            8'd12: return "rand_wr_count";
            8'd13: return "rand_end_pulses";
            8'd14: return "drain_timeout";
            8'd15: return "reset_wait_timeout";
            8'd16: return "boundary_wr_count";
            8'd17: return "reset_no_end_pulse";
            8'd18: return "boundary_req_cycles";
            default: return "unnamed";
        endcase
    endfunction

    // Compare process: one expected record per cycle, plus queued literal checks.
    always @(negedge clock) begin
        act_obs = {busy, done, fail, fail_code, rd_row, rd_col, check_req,
                   check_row, check_col, check_digit, wr_en, wr_row, wr_col, wr_digit};
        if (exp_q.size() > 0) begin
            exp_obs = exp_q.pop_front();
            vectors++;
            if (act_obs !== exp_obs) begin
                miscompares++;
                $display("FAIL cycle_outputs vector %0d: dut=%h model=%h", vectors, act_obs, exp_obs);
            end
        end
        while (lit_q.size() > 0) begin
            lit_item = lit_q.pop_front();
            vectors++;
            if (lit_item.act != lit_item.exp) begin
                miscompares++;
                $display("FAIL %s: got %0d expected %0d", lit_name(lit_item.id),
                         lit_item.act, lit_item.exp);
            end
        end
        if (wr_en === 1'b1) dut_wr_cnt++;
        if (done === 1'b1) dut_done_cnt++;
        if (fail === 1'b1) dut_fail_cnt++;
    end

    task automatic lit(input int id, input int a, input int x);
        lit_t lc;
        lc.id  = 8'(id);
        lc.act = a;
        lc.exp = x;
        lit_q.push_back(lc);
    endtask

    task automatic push_idle(input int n);
        obs_t e;
        e = '0;
        e.fc = m_fc;
        e.rr = m_rr;
        e.rc = m_rc;
        repeat (n) exp_q.push_back(e);
    endtask

    task automatic push_fail(input int r, input int c, input int code);
        obs_t e;
        e = '0;
        e.fail = 1'b1;
        e.fc = 2'(code);
        e.rr = 4'(r);
        e.rc = 4'(c);
        exp_q.push_back(e);
        m_rr = 4'(r);
        m_rc = 4'(c);
        m_fc = 2'(code);
    endtask

    // Expected outputs for a whole scan, starting with the cycle start is high.
    task automatic push_scan();
        obs_t e, b, q, w;
        bit   accepted;
        int   r, c;
        push_idle(1);
        m_fc = 2'd0;
        for (int idx = 0; idx < GN * GN; idx++) begin
            r = idx / GN;
            c = idx % GN;
            b = '0;
            b.busy = 1'b1;
            b.rr = 4'(r);
            b.rc = 4'(c);
            exp_q.push_back(b);
            exp_q.push_back(b);
            if (fixed_tab[r][c] == 0) begin
                accepted = 1'b0;
                for (int d = 1; d <= GN; d++) begin
                    q = b;
                    q.req = 1'b1;
                    q.cr = 4'(r);
                    q.cc = 4'(c);
                    q.cd = 4'(d);
                    if (lat_tab[r][c] == 0 || lat_tab[r][c] + 1 > TO) begin
                        repeat (TO) exp_q.push_back(q);
                        push_fail(r, c, 2);
                        return;
                    end
                    repeat (lat_tab[r][c] + 1) exp_q.push_back(q);
                    if (d == acc_tab[r][c]) begin
                        w = b;
                        w.wr = 1'b1;
                        w.wrr = 4'(r);
                        w.wrc = 4'(c);
                        w.wrd = 4'(d);
                        exp_q.push_back(w);
                        accepted = 1'b1;
                        break;
                    end
                    if (d < GN) exp_q.push_back(b);
                end
                if (!accepted) begin
                    push_fail(r, c, 1);
                    return;
                end
            end
            exp_q.push_back(b);
        end
        e = '0;
        e.done = 1'b1;
        exp_q.push_back(e);
        m_rr = 4'd0;
        m_rc = 4'd0;
        m_fc = 2'd0;
    endtask

    function automatic int q_count(input int kind);
        int n = 0;
        foreach (exp_q[i]) begin
            case (kind)
                0: if (exp_q[i].busy) n++;
                1: if (exp_q[i].wr) n++;
                default: if (exp_q[i].req) n++;
            endcase
        end
        return n;
    endfunction

    function automatic int done_offset();
        int first = -1;
        int dn = -1;
        foreach (exp_q[i]) begin
            if (exp_q[i].busy && first < 0) first = i;
            if (exp_q[i].done && dn < 0) dn = i;
        end
        return dn - first;
    endfunction

    task automatic clear_grid();
        for (int r = 0; r < GN; r++)
            for (int c = 0; c < GN; c++) begin
                fixed_tab[r][c] = 1;
                acc_tab[r][c]   = 1;
                lat_tab[r][c]   = 1;
            end
    endtask

    task automatic begin_scan();
        snap_wr   = dut_wr_cnt;
        snap_done = dut_done_cnt;
        snap_fail = dut_fail_cnt;
        start = 1'b1;
        push_scan();
    endtask

    // Run until the expected queue empties; optionally pulse start while busy.
    task automatic drain(input bit rnd);
        int n = 0;
        while (exp_q.size() > 0 && n < 20000) begin
            @(posedge clock);
            #1;
            start = rnd && (exp_q.size() >= 2) && ($urandom_range(0, 4) == 0);
            n++;
        end
        start = 1'b0;
        if (exp_q.size() > 0) begin
            lit(14, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic finish_scan(input bit rnd);
        drain(rnd);
        push_idle(2);
        drain(1'b0);
    endtask

    initial begin
        int mc;
        start = 1'b0;
        reset = 1'b1;
        clear_grid();
        @(posedge clock);
        #1;
        push_idle(1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        push_idle(1);
        drain(1'b0);

        // All cells given: 243 busy cycles, no requests or writes.
        begin_scan();
        lit(1, q_count(0), 243);
        lit(2, done_offset(), 243);
        finish_scan(1'b0);
        lit(3, dut_wr_cnt - snap_wr, 0);
        lit(4, dut_done_cnt - snap_done, 1);

        // Only (0,0) free; digits 1-3 rejected, 4 accepted, 1-cycle ack latency.
        fixed_tab[0][0] = 0;
        acc_tab[0][0] = 4;
        lat_tab[0][0] = 1;
        begin_scan();
        lit(5, q_count(2), 8);
        finish_scan(1'b0);
        lit(6, dut_wr_cnt - snap_wr, 1);
        lit(7, dut_done_cnt - snap_done, 1);

        // Only (4,7) free and every digit rejected.
        clear_grid();
        fixed_tab[4][7] = 0;
        acc_tab[4][7] = 0;
        lat_tab[4][7] = 2;
        begin_scan();
        finish_scan(1'b0);
        lit(8, dut_fail_cnt - snap_fail, 1);
        lit(9, dut_wr_cnt - snap_wr, 0);

        // Checker never answers: timeout after 15 request cycles.
        clear_grid();
        fixed_tab[1][2] = 0;
        lat_tab[1][2] = 0;
        begin_scan();
        lit(10, q_count(2), 15);
        finish_scan(1'b0);
        lit(11, dut_fail_cnt - snap_fail, 1);

        // Ack on the last allowed cycle wins; one cycle later times out.
        clear_grid();
        fixed_tab[0][5] = 0;
        acc_tab[0][5] = 1;
        lat_tab[0][5] = 14;
        fixed_tab[0][6] = 0;
        acc_tab[0][6] = 1;
        lat_tab[0][6] = 15;
        begin_scan();
        lit(18, q_count(2), 30);
        finish_scan(1'b0);
        lit(16, dut_wr_cnt - snap_wr, 1);

        // Reset while requesting on (2,3).
        clear_grid();
        fixed_tab[2][3] = 0;
        lat_tab[2][3] = 0;
        begin_scan();
        begin
            int n = 0;
            bit found = 1'b0;
            while (n < 300 && !found) begin
                @(posedge clock);
                #1;
                start = 1'b0;
                if (check_req === 1'b1) found = 1'b1;
                n++;
            end
            if (!found) lit(15, 0, 1);
        end
        reset = 1'b1;
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        m_rr = 4'd0;
        m_rc = 4'd0;
        m_fc = 2'd0;
        push_idle(1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        push_idle(2);
        drain(1'b0);
        lit(17, (dut_done_cnt - snap_done) + (dut_fail_cnt - snap_fail), 0);

        // Randomized grids with stray start pulses during each scan.
        for (int s = 0; s < 6; s++) begin
            for (int r = 0; r < GN; r++)
                for (int c = 0; c < GN; c++) begin
                    fixed_tab[r][c] = ($urandom_range(0, 3) != 0) ? 1 : 0;
                    acc_tab[r][c]   = $urandom_range(1, 9);
                    lat_tab[r][c]   = $urandom_range(1, 4);
                    if ($urandom_range(0, 119) == 0) acc_tab[r][c] = 0;
                    if ($urandom_range(0, 119) == 0)
                        lat_tab[r][c] = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(13, 15);
                end
            begin_scan();
            mc = q_count(1);
            finish_scan(1'b1);
            lit(12, dut_wr_cnt - snap_wr, mc);
            lit(13, (dut_done_cnt - snap_done) + (dut_fail_cnt - snap_fail), 1);
        end

        @(posedge clock);
        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
